lim_brick_array_ctrl: RTL and testbench
=======================================

# lim_brick_array_ctrl

Request-side controller for a stack of `NUM_BRICKS` LIM SRAM bricks that share one global read bitline and one write bitline pair. It accepts word read and write requests over a valid/ready interface. It decodes each word address to a one-hot wordline, drives the differential write bitlines and the per-brick read enables, and captures the shared `ARBL` bus. Read data is returned in order through a response FIFO with backpressure. The block sits between the SpMV merge datapath and the brick stack.

## Interface
- `BL_WIDTH`, default `LIM_BRICK_WORD_SIZE`: word width.
- `ADDR_WIDTH`, default `BITS_ADDR_LIM_BRICK`: word address width within one brick.
- `WL_WIDTH`, default `LIM_BRICK_WORD_NUM`: wordlines per brick; equals 2^ADDR_WIDTH.
- `NUM_BRICKS`, default 4: number of bricks in the stack.
- `SEL_WIDTH`, default 2: brick-select field width.
- `RSP_DEPTH`, default 4: response FIFO depth (power of 2, ≥2).

Ports:
- `CLK` in 1: clock.
- `RST` in 1: synchronous, active-high reset.
- `REQ_VALID` in 1: request valid.
- `REQ_READY` out 1: request accepted on a posedge when high together with `REQ_VALID`.
- `REQ_WE` in 1: 1 = write, 0 = read.
- `REQ_ADDR` in SEL_WIDTH+ADDR_WIDTH: upper bits select the brick, lower bits select the word.
- `REQ_WDATA` in BL_WIDTH: write data.
- `RSP_VALID` out 1: response FIFO head valid.
- `RSP_READY` in 1: pops the head when high together with `RSP_VALID`.
- `RSP_RDATA` out BL_WIDTH: read data.
- `RSP_ERR` out 1: response came from an out-of-range brick select.
- `BLK_RE` out NUM_BRICKS: per-brick read enable.
- `DRWL` out NUM_BRICKS*WL_WIDTH: per-brick one-hot read wordlines; brick b uses slice [b*WL_WIDTH +: WL_WIDTH].
- `DWWL` out NUM_BRICKS*WL_WIDTH: per-brick one-hot write wordlines, sliced the same way.
- `WBL` out BL_WIDTH: write bitline.
- `WBL_B` out BL_WIDTH: complement write bitline.
- `ARBL` in BL_WIDTH: shared read bitline, driven by the selected brick, otherwise high-Z.

## Operation
- **Issue stage.** An accepted request is registered into the brick-drive outputs for exactly one cycle, the issue cycle. In all other cycles `BLK_RE`, `DRWL`, `DWWL`, `WBL` and `WBL_B` are all-zero.
- **Read.** Sets `BLK_RE[sel]` and the single `DRWL` bit `sel*WL_WIDTH+word`. `DWWL`, `WBL` and `WBL_B` stay 0.
- **Write.** Sets the single `DWWL` bit, `WBL=REQ_WDATA` and `WBL_B=~REQ_WDATA`. `BLK_RE` and `DRWL` stay 0. A write produces no response.
- **Out-of-range select.** When `sel ≥ NUM_BRICKS`, no brick signal is asserted.
  - A read still enqueues a response with `RSP_RDATA=0` and `RSP_ERR=1`.
  - A write is dropped silently.
- **Read pipeline.** The issue stage, then the capture stage, then the response FIFO.
- **Capture.** The capture register samples `ARBL` on the negedge of `CLK` in the cycle after issue. This is the window in which the brick drives its posedge-registered data and before it releases the bus. It is the only negedge element in the block.
- **Enqueue.** On the following posedge the captured word, or 0/ERR for an out-of-range read, is pushed into the FIFO.
- **Credits.** `credits = RSP_DEPTH − fifo_count − reads_in_flight`, where `reads_in_flight` counts reads in the issue and capture stages (0..2).
  - `REQ_READY = (credits ≠ 0)` for all requests, reads and writes, to keep ordering simple.
  - The FIFO therefore never overflows. A pop in the same cycle frees its credit only from the next cycle.
- **Ordering.** Strictly one request per cycle, in order.
  - A write followed by a read of the same address in the next cycle returns the new data: the brick writes at the posedge that ends the write's issue cycle, and reads one posedge later.
- **FIFO.** Circular pointers with wrap-around. A simultaneous push and pop at full or empty is legal; the count is unchanged.

## Timing
- **Reset.** In the cycle after `RST` is sampled high:
  - all brick outputs are 0;
  - `REQ_READY=0` while `RST` is high, then 1 in the first cycle after release;
  - `RSP_VALID=0`, `RSP_RDATA=0`, `RSP_ERR=0`;
  - the FIFO is empty, credits equal `RSP_DEPTH`, and the issue and capture stages are cleared.
- **Reset mid-operation.** In-flight reads are discarded and produce no response. A write in its issue cycle when reset is sampled may still complete in the brick.
- **Latency.** Request accepted at edge E0. Brick signals are high during E0→E1. The brick samples at E1. Capture happens at the negedge between E1 and E2. The push is at E2, and `RSP_VALID` is high from E2, i.e. 2 cycles after acceptance when the FIFO is empty.
- **Throughput.** One read per cycle is sustained while `RSP_READY=1`.

## Test plan
- **Write then read back.** Reset, then with WL_WIDTH=16 and BL_WIDTH=32: write 0xDEADBEEF to brick 2 word 5, then read it back.
  - Write issue cycle: `DWWL` bit 37 is the only bit set, `WBL=0xDEADBEEF`, `WBL_B=0x21524110`.
  - The read returns 0xDEADBEEF with `RSP_ERR=0`, 2 cycles after acceptance.
- **Back-to-back reads.** Preload words 0..7 of brick 0 with values 0x100+i, then read all 8 back-to-back with `RSP_READY=1`. Expect 8 responses in order on consecutive cycles and `REQ_READY` constantly 1.
- **Backpressure.** Hold `RSP_READY=0` and issue reads.
  - Exactly `RSP_DEPTH` reads are accepted, then `REQ_READY=0`.
  - Raise `RSP_READY`: responses drain in order, and `REQ_READY` returns 1 the cycle after the first pop.
- **Out-of-range select.** With NUM_BRICKS=3, read at sel=3. Expect no `BLK_RE`/`DRWL` activity and a response of 0 with `RSP_ERR=1`.
- **Write/read same address.** Write A to an address, then read the same address in the next cycle. The read returns A.
- **Reset with reads in flight.** Assert `RST` with 2 reads in flight. No response appears afterward, and all outputs are at their reset values the cycle after.

Source files
------------

// File: rtl/lim_brick_array_ctrl.sv
// Request-side controller for a stack of LIM SRAM bricks sharing one read bitline and one write bitline pair.
// Issues one word access per cycle, samples ARBL on the negedge and returns reads in order through a credited FIFO.
module lim_brick_array_ctrl #(
    parameter int BL_WIDTH   = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int WL_WIDTH   = 16,
    parameter int NUM_BRICKS = 4,
    parameter int SEL_WIDTH  = 2,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic                             REQ_VALID,
    output logic                             REQ_READY,
    input  logic                             REQ_WE,
    input  logic [SEL_WIDTH+ADDR_WIDTH-1:0]  REQ_ADDR,
    input  logic [BL_WIDTH-1:0]              REQ_WDATA,
    output logic                             RSP_VALID,
    input  logic                             RSP_READY,
    output logic [BL_WIDTH-1:0]              RSP_RDATA,
    output logic                             RSP_ERR,
    output logic [NUM_BRICKS-1:0]            BLK_RE,
    output logic [NUM_BRICKS*WL_WIDTH-1:0]   DRWL,
    output logic [NUM_BRICKS*WL_WIDTH-1:0]   DWWL,
    output logic [BL_WIDTH-1:0]              WBL,
    output logic [BL_WIDTH-1:0]              WBL_B,
    input  logic [BL_WIDTH-1:0]              ARBL
);

    localparam int WL_TOTAL = NUM_BRICKS * WL_WIDTH;
    localparam int PTR_W    = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W    = PTR_W + 1;

    logic [SEL_WIDTH-1:0]  req_sel;
    logic [ADDR_WIDTH-1:0] req_word;
    logic                  req_oor;
    logic                  req_fire;
    logic [WL_WIDTH-1:0]   word_oh;

    logic [NUM_BRICKS-1:0] blk_re_q, blk_re_d;
    logic [WL_TOTAL-1:0]   drwl_q, drwl_d;
    logic [WL_TOTAL-1:0]   dwwl_q, dwwl_d;
    logic [BL_WIDTH-1:0]   wbl_q, wbl_d;
    logic [BL_WIDTH-1:0]   wbl_b_q, wbl_b_d;
    logic                  iss_rd_q, iss_rd_d;
    logic                  iss_err_q, iss_err_d;

    logic                  cap_vld_q;
    logic                  cap_err_q;
    logic [BL_WIDTH-1:0]   cap_data_q;

    logic [BL_WIDTH-1:0]   fifo_data_q [RSP_DEPTH];
    logic                  fifo_err_q  [RSP_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic [BL_WIDTH-1:0]   push_data;
    int                    credits;

    assign req_sel  = REQ_ADDR[SEL_WIDTH+ADDR_WIDTH-1 -: SEL_WIDTH];
    assign req_word = REQ_ADDR[ADDR_WIDTH-1:0];
    assign req_oor  = (int'(req_sel) >= NUM_BRICKS);
    assign req_fire = REQ_VALID && REQ_READY;
    assign word_oh  = {{(WL_WIDTH-1){1'b0}}, 1'b1} << req_word;

    // Credits cover the FIFO plus every read still in the issue or capture stage.
    always_comb begin
        credits = RSP_DEPTH - int'(count_q) - int'(iss_rd_q) - int'(cap_vld_q);
    end

    assign REQ_READY = !RST && (credits != 0);

    always_comb begin
        blk_re_d  = '0;
        drwl_d    = '0;
        dwwl_d    = '0;
        wbl_d     = '0;
        wbl_b_d   = '0;
        iss_rd_d  = 1'b0;
        iss_err_d = 1'b0;
        if (req_fire) begin
            iss_rd_d  = !REQ_WE;
            iss_err_d = !REQ_WE && req_oor;
            for (int b = 0; b < NUM_BRICKS; b++) begin
                if (int'(req_sel) == b) begin
                    if (REQ_WE) begin
                        dwwl_d[b*WL_WIDTH +: WL_WIDTH] = word_oh;
                    end else begin
                        drwl_d[b*WL_WIDTH +: WL_WIDTH] = word_oh;
                        blk_re_d[b]                    = 1'b1;
                    end
                end
            end
            if (REQ_WE && !req_oor) begin
                wbl_d   = REQ_WDATA;
                wbl_b_d = ~REQ_WDATA;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            blk_re_q  <= '0;
            drwl_q    <= '0;
            dwwl_q    <= '0;
            wbl_q     <= '0;
            wbl_b_q   <= '0;
            iss_rd_q  <= 1'b0;
            iss_err_q <= 1'b0;
            cap_vld_q <= 1'b0;
            cap_err_q <= 1'b0;
        end else begin
            blk_re_q  <= blk_re_d;
            drwl_q    <= drwl_d;
            dwwl_q    <= dwwl_d;
            wbl_q     <= wbl_d;
            wbl_b_q   <= wbl_b_d;
            iss_rd_q  <= iss_rd_d;
            iss_err_q <= iss_err_d;
            cap_vld_q <= iss_rd_q;
            cap_err_q <= iss_err_q;
        end
    end

    assign BLK_RE = blk_re_q;
    assign DRWL   = drwl_q;
    assign DWWL   = dwwl_q;
    assign WBL    = wbl_q;
    assign WBL_B  = wbl_b_q;

    // The brick holds its posedge-registered word on ARBL only until the next posedge,
    // so mid-cycle is the one safe sampling point.
    always_ff @(negedge CLK) begin
        if (RST) begin
            cap_data_q <= '0;
        end else if (cap_vld_q && !cap_err_q) begin
            cap_data_q <= ARBL;
        end
    end

    assign fifo_push = cap_vld_q;
    assign fifo_pop  = RSP_VALID && RSP_READY;
    assign push_data = cap_err_q ? '0 : cap_data_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (fifo_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (fifo_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (fifo_push && !fifo_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!fifo_push && fifo_pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (fifo_push) begin
            fifo_data_q[wr_ptr_q] <= push_data;
            fifo_err_q[wr_ptr_q]  <= cap_err_q;
        end
    end

    assign RSP_VALID = (count_q != '0);
    assign RSP_RDATA = RSP_VALID ? fifo_data_q[rd_ptr_q] : '0;
    assign RSP_ERR   = RSP_VALID ? fifo_err_q[rd_ptr_q] : 1'b0;

endmodule

// File: tb/tb_lim_brick_array_ctrl.sv
// Bench for lim_brick_array_ctrl: brick-stack model on the bitlines, array reference model and response scoreboard.
module tb_lim_brick_array_ctrl;

    localparam int NB  = 3;
    localparam int WLW = 16;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } rsp_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        REQ_VALID = 1'b0;
    logic        REQ_WE = 1'b0;
    logic [5:0]  REQ_ADDR = '0;
    logic [31:0] REQ_WDATA = '0;
    logic        RSP_READY = 1'b1;
    logic [31:0] ARBL = '0;
    logic        REQ_READY;
    logic        RSP_VALID;
    logic [31:0] RSP_RDATA;
    logic        RSP_ERR;
    logic [2:0]  BLK_RE;
    logic [47:0] DRWL;
    logic [47:0] DWWL;
    logic [31:0] WBL;
    logic [31:0] WBL_B;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit mon_en = 1'b0;

    rsp_t sb[$];
    int   pop_cyc[$];

    logic [31:0] brick_mem [NB][WLW];
    logic [31:0] ref_mem   [NB][WLW];

    lim_brick_array_ctrl #(
        .BL_WIDTH(32), .ADDR_WIDTH(4), .WL_WIDTH(WLW),
        .NUM_BRICKS(NB), .SEL_WIDTH(2), .RSP_DEPTH(4)
    ) dut (
        .CLK(CLK), .RST(RST),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
        .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
        .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
        .BLK_RE(BLK_RE), .DRWL(DRWL), .DWWL(DWWL),
        .WBL(WBL), .WBL_B(WBL_B), .ARBL(ARBL)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Brick stack: wordline/bitline levels are sampled mid-cycle, acted on at the posedge;
    // a released ARBL is modelled as random junk so a mistimed capture is visible.
    logic [2:0]  s_re = '0;
    logic [47:0] s_drwl = '0;
    logic [47:0] s_dwwl = '0;
    logic [31:0] s_wbl = '0;
    logic [31:0] bus_v;

    always @(negedge CLK) begin
        s_re   = BLK_RE;
        s_drwl = DRWL;
        s_dwwl = DWWL;
        s_wbl  = WBL;
    end

    always @(posedge CLK) begin
        bus_v = $urandom;
        for (int b = 0; b < NB; b++) begin
            for (int w = 0; w < WLW; w++) begin
                if (s_dwwl[b*WLW+w]) brick_mem[b][w] = s_wbl;
                if (s_re[b] && s_drwl[b*WLW+w]) bus_v = brick_mem[b][w];
            end
        end
        ARBL = bus_v;
    end

    // Monitor: drive check for the issue cycle, response check, then reference update for the next edge.
    bit          iss_v = 1'b0;
    bit          iss_we;
    int          iss_sel;
    int          iss_word;
    logic [31:0] iss_d;
    logic [2:0]  e_re;
    logic [47:0] e_drwl, e_dwwl;
    logic [31:0] e_wbl, e_wblb;
    rsp_t        e_rsp, n_rsp;

    always @(negedge CLK) begin
        if (mon_en) begin
            e_re = '0; e_drwl = '0; e_dwwl = '0; e_wbl = '0; e_wblb = '0;
            if (iss_v && iss_sel < NB) begin
                if (iss_we) begin
                    e_dwwl = 48'd1 << (iss_sel * WLW + iss_word);
                    e_wbl  = iss_d;
                    e_wblb = ~iss_d;
                end else begin
                    e_re   = 3'd1 << iss_sel;
                    e_drwl = 48'd1 << (iss_sel * WLW + iss_word);
                end
            end
            check("blk_re", 64'(BLK_RE), 64'(e_re));
            check("drwl", 64'(DRWL), 64'(e_drwl));
            check("dwwl", 64'(DWWL), 64'(e_dwwl));
            check("wbl", 64'(WBL), 64'(e_wbl));
            check("wbl_b", 64'(WBL_B), 64'(e_wblb));

            if (RSP_VALID && RSP_READY) begin
                check("rsp_expected", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    e_rsp = sb.pop_front();
                    check("rsp_data", 64'(RSP_RDATA), 64'(e_rsp.data));
                    check("rsp_err", 64'(RSP_ERR), 64'(e_rsp.err));
                    pop_cyc.push_back(cyc);
                end
            end

            if (RST) begin
                sb.delete();
                iss_v = 1'b0;
            end else begin
                iss_v = REQ_VALID && REQ_READY;
                if (iss_v) begin
                    iss_we   = REQ_WE;
                    iss_sel  = int'(REQ_ADDR[5:4]);
                    iss_word = int'(REQ_ADDR[3:0]);
                    iss_d    = REQ_WDATA;
                    if (iss_we) begin
                        if (iss_sel < NB) ref_mem[iss_sel][iss_word] = iss_d;
                    end else begin
                        n_rsp.err  = (iss_sel >= NB);
                        n_rsp.data = '0;
                        if (iss_sel < NB) n_rsp.data = ref_mem[iss_sel][iss_word];
                        sb.push_back(n_rsp);
                    end
                end
            end
        end
    end

    task automatic send(input bit we, input int sel, input int word, input logic [31:0] d,
                        output int waits);
        REQ_VALID = 1'b1;
        REQ_WE    = we;
        REQ_ADDR  = {2'(sel), 4'(word)};
        REQ_WDATA = d;
        waits     = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (REQ_READY) break;
            waits++;
            @(posedge CLK);
            #1;
            RSP_READY = 1'b1;
        end
        if (waits >= 40) begin
            failures++;
            $display("FAIL send_timeout: REQ_READY low for %0d cycles, required within 40", waits);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        REQ_VALID = 1'b0;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required under 200000 time units");
        $fatal(1);
    end

    initial begin
        int          wt;
        int          n0;
        int          acc;
        int          sel;
        int          word;
        logic [31:0] v;

        for (int b = 0; b < NB; b++) begin
            for (int w = 0; w < WLW; w++) begin
                v = $urandom;
                brick_mem[b][w] = v;
                ref_mem[b][w]   = v;
            end
        end

        // reset values
        @(posedge CLK);
        mon_en = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        check("rst_req_ready", 64'(REQ_READY), 64'd0);
        check("rst_rsp_valid", 64'(RSP_VALID), 64'd0);
        check("rst_rsp_rdata", 64'(RSP_RDATA), 64'd0);
        check("rst_rsp_err", 64'(RSP_ERR), 64'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        check("ready_after_reset", 64'(REQ_READY), 64'd1);
        @(posedge CLK);
        #1;

        // write 0xDEADBEEF to brick 2 word 5, read it back, check latency
        send(1'b1, 2, 5, 32'hDEADBEEF, wt);
        REQ_VALID = 1'b0;
        @(negedge CLK);
        check("wr_dwwl_bit37", 64'(DWWL), 64'h0000_0020_0000_0000);
        check("wr_wbl", 64'(WBL), 64'h0000_0000_DEAD_BEEF);
        check("wr_wbl_b", 64'(WBL_B), 64'h0000_0000_2152_4110);
        @(posedge CLK);
        #1;
        send(1'b0, 2, 5, 32'h0, wt);
        REQ_VALID = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        check("rd_lat_not_yet", 64'(RSP_VALID), 64'd0);
        @(negedge CLK);
        check("rd_lat_valid", 64'(RSP_VALID), 64'd1);
        check("rd_lat_data", 64'(RSP_RDATA), 64'h0000_0000_DEAD_BEEF);
        check("rd_lat_err", 64'(RSP_ERR), 64'd0);
        idle(3);

        // back-to-back reads of brick 0 words 0..7
        for (int i = 0; i < 8; i++) send(1'b1, 0, i, 32'h100 + 32'(i), wt);
        n0 = pop_cyc.size();
        for (int i = 0; i < 8; i++) begin
            send(1'b0, 0, i, 32'h0, wt);
            check("b2b_req_ready", 64'(wt), 64'd0);
        end
        idle(6);
        check("b2b_count", 64'(pop_cyc.size() - n0), 64'd8);
        if (pop_cyc.size() - n0 == 8)
            check("b2b_consecutive", 64'(pop_cyc[n0+7] - pop_cyc[n0]), 64'd7);

        // backpressure: exactly RSP_DEPTH reads accepted
        RSP_READY = 1'b0;
        acc = 0;
        REQ_VALID = 1'b1;
        REQ_WE    = 1'b0;
        REQ_ADDR  = {2'($urandom_range(0, 2)), 4'($urandom_range(0, 15))};
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (REQ_READY) acc++;
            @(posedge CLK);
            #1;
            REQ_ADDR = {2'($urandom_range(0, 2)), 4'($urandom_range(0, 15))};
        end
        check("bp_accepted", 64'(acc), 64'd4);
        @(negedge CLK);
        check("bp_ready_low", 64'(REQ_READY), 64'd0);
        @(posedge CLK);
        #1;
        REQ_VALID = 1'b0;
        RSP_READY = 1'b1;
        @(negedge CLK);
        check("bp_ready_pop_cycle", 64'(REQ_READY), 64'd0);
        @(posedge CLK);
        #1;
        @(negedge CLK);
        check("bp_ready_after_pop", 64'(REQ_READY), 64'd1);
        idle(6);

        // out-of-range select
        send(1'b0, 3, 5, 32'h0, wt);
        REQ_VALID = 1'b0;
        @(negedge CLK);
        check("oor_blk_re", 64'(BLK_RE), 64'd0);
        check("oor_drwl", 64'(DRWL), 64'd0);
        @(posedge CLK);
        #1;
        send(1'b1, 3, 9, $urandom, wt);
        idle(4);

        // write then read same address on consecutive cycles
        for (int k = 0; k < 4; k++) begin
            sel  = $urandom_range(0, 2);
            word = $urandom_range(0, 15);
            send(1'b1, sel, word, $urandom, wt);
            send(1'b0, sel, word, 32'h0, wt);
        end
        idle(4);

        // randomized traffic with random response backpressure
        for (int i = 0; i < 150; i++) begin
            RSP_READY = ($urandom_range(0, 3) != 0);
            send(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 15), $urandom, wt);
            if ($urandom_range(0, 4) == 0) idle(1);
        end
        RSP_READY = 1'b1;
        idle(8);
        check("random_drained", 64'(sb.size()), 64'd0);

        // reset with two reads in flight
        send(1'b0, 1, 3, 32'h0, wt);
        send(1'b0, 2, 7, 32'h0, wt);
        RST = 1'b1;
        REQ_VALID = 1'b0;
        n0 = pop_cyc.size();
        @(posedge CLK);
        @(negedge CLK);
        check("mid_rst_req_ready", 64'(REQ_READY), 64'd0);
        check("mid_rst_rsp_valid", 64'(RSP_VALID), 64'd0);
        check("mid_rst_rsp_rdata", 64'(RSP_RDATA), 64'd0);
        check("mid_rst_rsp_err", 64'(RSP_ERR), 64'd0);
        check("mid_rst_blk_re", 64'(BLK_RE), 64'd0);
        check("mid_rst_drwl", 64'(DRWL), 64'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        check("mid_rst_ready_back", 64'(REQ_READY), 64'd1);
        idle(6);
        check("mid_rst_no_rsp", 64'(pop_cyc.size() - n0), 64'd0);
        check("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
